// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared definitions for the 8-requester round-robin mux arbiter:
// state encoding, sizing constants and the owner-to-mux-select mapping.
package mux8_rr_arbiter_pkg;

   localparam int unsigned NUM_REQ = 8;
   localparam int unsigned SEL_W   = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_e;

   // The mux numbers its Sel pins MSB-first, so the owner index is bit-reversed.
   function automatic logic [SEL_W-1:0] enc(input logic [SEL_W-1:0] i);
      return {i[0], i[1], i[2]};
   endfunction

endpackage

// File: rtl/mux8_rr_arbiter_pick.sv
// Combinational round-robin picker: first set req bit at or above pointer,
// wrapping modulo 8 (rotate, priority-encode, unrotate).
module rr_pick8
   import mux8_rr_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   pointer,
   output logic               found,
   output logic [SEL_W-1:0]   idx
);

   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]   rot;
   logic [SEL_W-1:0]     off;
   logic                 hit;

   always_comb begin
      dbl = {req, req};
      rot = NUM_REQ'(dbl >> pointer);
      off = '0;
      hit = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (rot[i] && !hit) begin
            off = SEL_W'(i);
            hit = 1'b1;
         end
      end
      found = hit;
      idx   = pointer + off;
   end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for a shared 8:1 mux datapath: bounded hold while
// others wait, one dead cycle between owners, registered gnt/sel/busy.
module mux8_rr_arbiter
   import mux8_rr_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 4
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [SEL_W-1:0]   sel,
   output logic               busy
);

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   owner_q, owner_d;
   logic [SEL_W-1:0]   pointer_q, pointer_d;
   logic [7:0]         hold_cnt_q, hold_cnt_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic               busy_q, busy_d;

   logic               found;
   logic [SEL_W-1:0]   win_idx;
   logic [NUM_REQ-1:0] owner_oh;
   logic               hold_done;

   rr_pick8 u_pick (
      .req     (req),
      .pointer (pointer_q),
      .found   (found),
      .idx     (win_idx)
   );

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      pointer_d  = pointer_q;
      hold_cnt_d = hold_cnt_q;
      gnt_d      = gnt_q;
      sel_d      = sel_q;
      busy_d     = busy_q;
      owner_oh   = NUM_REQ'(1) << owner_q;
      hold_done  = hold_cnt_q >= 8'(MAX_HOLD);

      unique case (state_q)
         IDLE: begin
            gnt_d  = '0;
            busy_d = 1'b0;
            if (found) begin
               owner_d    = win_idx;
               gnt_d      = NUM_REQ'(1) << win_idx;
               sel_d      = enc(win_idx);
               busy_d     = 1'b1;
               hold_cnt_d = 8'd1;
               state_d    = GRANT;
            end
         end
         GRANT: begin
            // Owner drop and hold expiry share one release path.
            if (!req[owner_q] || (hold_done && (req & ~owner_oh) != '0)) begin
               gnt_d     = '0;
               busy_d    = 1'b0;
               pointer_d = owner_q + SEL_W'(1);
               state_d   = RELEASE;
            end else if (!hold_done) begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
         end
         RELEASE: begin
            gnt_d   = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         pointer_q  <= '0;
         hold_cnt_q <= '0;
         gnt_q      <= '0;
         sel_q      <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         pointer_q  <= pointer_d;
         hold_cnt_q <= hold_cnt_d;
         gnt_q      <= gnt_d;
         sel_q      <= sel_d;
         busy_q     <= busy_d;
      end
   end

   assign gnt  = gnt_q;
   assign sel  = sel_q;
   assign busy = busy_q;

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8-bit 8-to-1 mux datapath among 8 requesters.
- Generates the mux select plus a one-hot grant, with a bounded hold time and one dead cycle between owners.
- Sits beside the 8:1 mux: requester i drives mux input i (i=0..7 ↔ A..H); sel drives the mux Sel input directly.

Parameters:
MAX_HOLD, 4, max consecutive grant cycles while another requester is pending (legal 1..255)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req  in  8  level request, bit i = requester i; held high while it wants the datapath
gnt  out 8  registered one-hot grant; all-zero when no owner
sel  out 3  registered mux select for current/last owner, mux bit order (see Behaviour)
busy out 1  registered, 1 while gnt != 0

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). All outputs registered.
- Reset values: gnt=8'h00, sel=3'b000, busy=0, state=IDLE, pointer=0, hold_cnt=0.
- rst has priority over everything. Asserted mid-grant, it forces gnt=0 at the next edge; no dead cycle is owed afterwards.
- Select encoding, for owner index i (3-bit): sel[0]=i[2], sel[1]=i[1], sel[2]=i[0].
  - i=1 → sel=3'b100 (input B).
  - i=4 → sel=3'b001 (input E).
- Selection: search req starting at pointer, ascending modulo 8; the first set bit wins.
- States:
  - IDLE, at each edge:
    - if req==0: stay; gnt=0; sel holds its last value.
    - else: owner←winner; gnt←onehot(owner); sel←enc(owner); busy←1; hold_cnt←1; →GRANT.
  - GRANT, at each edge:
    - if req[owner]==0: →RELEASE.
    - else if hold_cnt>=MAX_HOLD and (req & ~onehot(owner))!=0: →RELEASE (preempt).
    - else: stay; hold_cnt←hold_cnt+1, saturating at MAX_HOLD.
    - Owner drop and hold expiry in the same cycle are treated as a single release.
  - Entering RELEASE: gnt←0; busy←0; sel holds; pointer←(owner+1) mod 8.
  - RELEASE: one mandatory dead cycle with gnt=0; →IDLE unconditionally. req is ignored here.
- Latency:
  - New request to grant, from IDLE: gnt visible the cycle after req is sampled high.
  - Owner release to next grant: gnt=0 for exactly 2 cycles (the RELEASE cycle and the IDLE arbitration cycle).
- A sole requester is never preempted; its grant persists indefinitely.
- A grant is never issued to a line whose req is low at the sampling edge.
- hold_cnt is 8 bits wide.
- Invariants: gnt is one-hot or zero; busy == |gnt.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2.
  - NUM_REQ=8.
  - SEL_W=3.
  - the enc(i) bit-reversal rule as a function/macro, so the mux wrapper and the arbiter share it.
- One sub-module, rr_pick8: combinational.
  - Inputs: req[7:0], pointer[2:0].
  - Outputs: found, idx[2:0].
  - Implemented as a rotate, priority-encode, unrotate.
- The top level holds the FSM, hold counter, pointer and output registers.

Test Plan:
- Reset: rst=1 for 2 cycles with req=8'hFF → gnt=8'h00, sel=3'b000, busy=0 throughout; first grant after rst falls is gnt=8'h01, sel=3'b000.
- Single requester and bit order: req=8'h02 → next cycle gnt=8'h02, sel=3'b100, busy=1. Drop req → gnt=8'h00 the next cycle, 2 idle cycles total. Then req=8'h10 → gnt=8'h10, sel=3'b001.
- Full load, MAX_HOLD=4: req=8'hFF held → grant order 0,1,2,…,7,0. Each grant lasts 4 cycles, separated by 2 gnt=0 cycles; sel sequence 000,100,010,110,001,101,011,111.
- Fairness wrap: req=8'h81 held → grants alternate 8'h01, 8'h80, 8'h01, 8'h80, never the same owner twice in a row.
- No preemption when alone: req=8'h08 held for 20 cycles → gnt=8'h08 continuously after the first grant. Then raise req[5] → preempt occurs on the next edge (hold_cnt already saturated): 2 dead cycles, then gnt=8'h20.
- Reset mid-grant: during gnt=8'h04, pulse rst for 1 cycle with req=8'h04 held → gnt=8'h00 the cycle after rst. The grant re-issues to index 2 one cycle after rst deasserts, since pointer was reset to 0 and index 2 is the first set bit.
